// File: rtl/filter_accel_udiv_seq_if.sv
// Valid/ready operand and result channels of the sequential unsigned divider.
interface filter_accel_udiv_seq_if #(
    parameter int unsigned din0_WIDTH = 18,
    parameter int unsigned din1_WIDTH = 11,
    parameter int unsigned dout_WIDTH = 7
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;
    logic                  dbz;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, rem, ovf, dbz
    );

    // Divider side
    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, rem, ovf, dbz
    );
endinterface

// File: rtl/filter_accel_udiv_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, with
// quotient saturation to the pixel width and divide-by-zero flagging.
module filter_accel_udiv_seq #(
    parameter int unsigned din0_WIDTH = 18,
    parameter int unsigned din1_WIDTH = 11,
    parameter int unsigned dout_WIDTH = 7
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    filter_accel_udiv_seq_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(din0_WIDTH);
    localparam int unsigned PREM_W = din1_WIDTH + 1;
    localparam logic [din0_WIDTH-1:0] QMAX = din0_WIDTH'(2**dout_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    // Dividend shifts out at the top while quotient bits shift in at the bottom
    logic [din0_WIDTH-1:0] dvd, dvd_nxt;
    logic [din1_WIDTH-1:0] dsr, dsr_nxt;
    logic [din1_WIDTH-1:0] prem, prem_nxt;
    logic                  in_ready_q, in_ready_nxt;
    logic                  out_valid_q, out_valid_nxt;
    logic [dout_WIDTH-1:0] dout_q, dout_nxt;
    logic [din1_WIDTH-1:0] rem_q, rem_nxt;
    logic                  ovf_q, ovf_nxt;
    logic                  dbz_q, dbz_nxt;

    logic [PREM_W-1:0]     trial;
    logic                  ge;
    logic [din1_WIDTH-1:0] step_rem;
    logic [din0_WIDTH-1:0] step_quo;

    // One restoring step: trial fits the divisor width once it is known to be >= divisor
    always_comb begin
        trial    = {prem, dvd[din0_WIDTH-1]};
        ge       = (trial >= {1'b0, dsr});
        step_rem = ge ? (trial[din1_WIDTH-1:0] - dsr) : trial[din1_WIDTH-1:0];
        step_quo = {dvd[din0_WIDTH-2:0], ge};
    end

    // Next-state and datapath/output next values
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dvd_nxt       = dvd;
        dsr_nxt       = dsr;
        prem_nxt      = prem;
        out_valid_nxt = out_valid_q;
        dout_nxt      = dout_q;
        rem_nxt       = rem_q;
        ovf_nxt       = ovf_q;
        dbz_nxt       = dbz_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_nxt  = bus.din0;
                    dsr_nxt  = bus.din1;
                    prem_nxt = '0;
                    cnt_nxt  = CNT_W'(din0_WIDTH - 1);
                    if (bus.din1 == '0) begin
                        state_nxt = DONE;
                        dout_nxt  = '1;
                        rem_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                prem_nxt = step_rem;
                dvd_nxt  = step_quo;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    ovf_nxt   = (step_quo > QMAX);
                    dout_nxt  = (step_quo > QMAX) ? '1 : step_quo[dout_WIDTH-1:0];
                    rem_nxt   = step_rem;
                    dbz_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // Result is presented the edge after entry; ready before that is ignored
                if (!out_valid_q) begin
                    out_valid_nxt = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt = (state_nxt == IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            prem        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dvd         <= dvd_nxt;
            dsr         <= dsr_nxt;
            prem        <= prem_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            dout_q      <= dout_nxt;
            rem_q       <= rem_nxt;
            ovf_q       <= ovf_nxt;
            dbz_q       <= dbz_nxt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.rem       = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_filter_accel_udiv_seq.sv
// Randomised bench for the sequential divider against an arithmetic reference.
module tb_filter_accel_udiv_seq;
    localparam int unsigned W0 = 18;
    localparam int unsigned W1 = 11;
    localparam int unsigned WO = 7;
    localparam int unsigned LAT = W0 + 1;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 ap_clk = ~ap_clk;

    filter_accel_udiv_seq_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) bus ();

    filter_accel_udiv_seq #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation, check latency, result, hold under backpressure and release
    task automatic run_op(input logic [W0-1:0] a, input logic [W1-1:0] b, input int bp);
        int n;
        int q;
        int e_dout, e_rem, e_ovf, e_dbz;
        bit stable;

        if (b == 0) begin
            e_dout = 2**WO - 1; e_rem = 0; e_ovf = 0; e_dbz = 1;
        end else begin
            q      = int'(a) / int'(b);
            e_rem  = int'(a) % int'(b);
            e_ovf  = (q > 2**WO - 1) ? 1 : 0;
            e_dout = e_ovf ? 2**WO - 1 : q;
            e_dbz  = 0;
        end

        n = 0;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);

        bus.in_valid  = 1'b1;
        bus.din0      = a;
        bus.din1      = b;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge ap_clk); #1;
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);

        n = 0;
        while (n < 40) begin
            if (n > 0 && bus.out_valid === 1'b1) break;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.din0      = W0'($urandom);
            bus.din1      = W1'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge ap_clk); #1;
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 32'(n), (b == 0) ? 32'd1 : 32'(LAT));
        check("dout", 32'(bus.dout), 32'(e_dout));
        check("rem",  32'(bus.rem),  32'(e_rem));
        check("ovf",  32'(bus.ovf),  32'(e_ovf));
        check("dbz",  32'(bus.dbz),  32'(e_dbz));

        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            bus.din0 = W0'($urandom);
            bus.din1 = W1'($urandom);
            @(posedge ap_clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                32'(bus.dout) !== 32'(e_dout) || 32'(bus.rem) !== 32'(e_rem) ||
                32'(bus.ovf) !== 32'(e_ovf) || 32'(bus.dbz) !== 32'(e_dbz))
                stable = 1'b0;
        end
        if (bp > 0) check("hold", 32'(stable), 32'd1);

        bus.out_ready = 1'b1;
        @(posedge ap_clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [W0-1:0] a;
        logic [W1-1:0] b;
        int            mode;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dout",      32'(bus.dout),      32'd0);
        check("rst_rem",       32'(bus.rem),       32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_dbz",       32'(bus.dbz),       32'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // Directed cases
        run_op(W0'(259969), W1'(2047), 0);
        run_op(W0'(1000),   W1'(7),    2);
        run_op(W0'(12345),  W1'(0),    1);
        run_op(W0'(50),     W1'(100),  10);
        run_op(W0'(262143), W1'(1),    0);
        run_op(W0'(0),      W1'(5),    0);

        // Reset on the 5th computation edge discards the operation
        bus.in_valid = 1'b1;
        bus.din0     = W0'(1000);
        bus.din1     = W1'(7);
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_dout",      32'(bus.dout),      32'd0);
        check("midrst_rem",       32'(bus.rem),       32'd0);
        check("midrst_ovf",       32'(bus.ovf),       32'd0);
        check("midrst_dbz",       32'(bus.dbz),       32'd0);
        run_op(W0'(200), W1'(10), 0);

        // Random regression mixing saturating, in-range and zero-divisor cases
        for (int k = 0; k < 2000; k++) begin
            mode = int'($urandom_range(0, 15));
            if (mode == 0) begin
                b = '0;
                a = W0'($urandom);
            end else if (mode < 8) begin
                b = W1'($urandom_range(1, 2047));
                a = W0'(int'(b) * int'($urandom_range(0, 127)) + int'($urandom_range(0, int'(b) - 1)));
            end else begin
                b = W1'($urandom_range(1, 2047));
                a = W0'($urandom);
            end
            run_op(a, b, (mode == 15) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
